// File: rtl/stc_pkg.sv
// Shared constants for the bit-serial complement array: word modes, lane FSM
// encoding and a constant-evaluable log2 helper for counter sizing.
package stc_pkg;
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_NEG  = 2'd1;
  localparam logic [1:0] MODE_ABS  = 2'd2;
  localparam logic [1:0] MODE_ONES = 2'd3;

  localparam logic [0:0] ST_COPY   = 1'b0;
  localparam logic [0:0] ST_INVERT = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/serial_negate_lane.sv
// One lane of the serial complementer: COPY/INVERT negation FSM plus the
// most-negative detector, both armed when a buffered word is loaded.
module serial_negate_lane
  import stc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [1:0]       word_mode,
  input  logic [WIDTH-1:0] word,
  input  logic             shift,
  input  logic             last,
  input  logic             b,
  output logic             out,
  output logic             ovf
);
  logic [0:0] st;
  logic       neg_en;
  logic       ones;
  logic       is_min;

  // The whole word is visible at load, so ABS can decide on the MSB up front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_COPY;
      neg_en <= 1'b0;
      ones   <= 1'b0;
      is_min <= 1'b0;
    end else if (load) begin
      st     <= ST_COPY;
      neg_en <= (word_mode == MODE_NEG) || ((word_mode == MODE_ABS) && word[WIDTH-1]);
      ones   <= (word_mode == MODE_ONES);
      is_min <= (word == {1'b1, {(WIDTH-1){1'b0}}});
    end else if (shift && neg_en && (st == ST_COPY) && b) begin
      st <= ST_INVERT;
    end
  end

  always_comb begin
    out = b;
    if (ones || (neg_en && (st == ST_INVERT))) out = ~b;
  end

  assign ovf = last && neg_en && is_min;
endmodule

// File: rtl/serial_twos_comp_array.sv
// Multi-lane, word-framed, LSB-first serial complement engine with per-word
// mode (pass/negate/abs/ones) and most-negative overflow flag.
module serial_twos_comp_array
  import stc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                t_clk,
  input  logic                r_n,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [CHANNELS-1:0] in_bit,
  input  logic [1:0]          mode,
  output logic                out_valid,
  output logic                out_sof,
  output logic [CHANNELS-1:0] out_bit,
  output logic [CHANNELS-1:0] ovf,
  output logic                err_frame
);
  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]                      icnt;
  logic [CW-1:0]                      ocnt;
  logic [1:0]                         mode_lat;
  logic [CHANNELS-1:0][WIDTH-1:0]     cap;
  logic [CHANNELS-1:0][WIDTH-1:0]     obuf;
  logic [CHANNELS-1:0][WIDTH-1:0]     word;
  logic                               busy;
  logic                               xfer;
  logic [CHANNELS-1:0]                lane_out;
  logic [CHANNELS-1:0]                lane_ovf;

  assign xfer = in_valid && !in_sof && (icnt == LAST);

  // Completed word = captured low bits plus the MSB arriving this beat.
  always_comb begin
    word = cap;
    for (int c = 0; c < CHANNELS; c++) word[c][WIDTH-1] = in_bit[c];
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      icnt      <= '0;
      mode_lat  <= MODE_PASS;
      cap       <= '0;
      err_frame <= 1'b0;
    end else if (in_valid) begin
      err_frame <= in_sof ? (icnt != '0) : (icnt == '0);
      if (in_sof) begin
        for (int c = 0; c < CHANNELS; c++) cap[c][0] <= in_bit[c];
        mode_lat <= mode;
        icnt     <= CW'(1);
      end else if (icnt != '0) begin
        for (int c = 0; c < CHANNELS; c++) cap[c][icnt] <= in_bit[c];
        icnt <= (icnt == LAST) ? '0 : icnt + 1'b1;
      end
    end else begin
      err_frame <= 1'b0;
    end
  end

  // A transfer may land on the edge that retires the last bit: load wins, no bubble.
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      obuf <= '0;
      busy <= 1'b0;
      ocnt <= '0;
    end else if (xfer) begin
      obuf <= word;
      busy <= 1'b1;
      ocnt <= '0;
    end else if (busy) begin
      for (int c = 0; c < CHANNELS; c++) obuf[c] <= {1'b0, obuf[c][WIDTH-1:1]};
      ocnt <= ocnt + 1'b1;
      if (ocnt == LAST) busy <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    serial_negate_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (t_clk),
      .rst_n     (r_n),
      .load      (xfer),
      .word_mode (mode_lat),
      .word      (word[c]),
      .shift     (busy),
      .last      (busy && (ocnt == LAST)),
      .b         (obuf[c][0]),
      .out       (lane_out[c]),
      .ovf       (lane_ovf[c])
    );
  end

  assign out_valid = busy;
  assign out_sof   = busy && (ocnt == '0);
  assign out_bit   = lane_out & {CHANNELS{busy}};
  assign ovf       = lane_ovf;
endmodule

// File: tb/tb_serial_twos_comp_array.sv
// Directed bench with an arithmetic reference model and an expected-beat
// scoreboard checked against the serial output stream.
module tb_serial_twos_comp_array;
  localparam int W  = 8;
  localparam int CH = 2;

  typedef struct {
    logic [CH-1:0] bits;
    logic          sof;
    logic [CH-1:0] ovf;
    int            cyc;
  } exp_t;

  logic          t_clk = 1'b0;
  logic          r_n;
  logic          in_valid, in_sof;
  logic [CH-1:0] in_bit;
  logic [1:0]    mode;
  logic          out_valid, out_sof, err_frame;
  logic [CH-1:0] out_bit, ovf;

  exp_t q[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   err_cyc = -1;
  bit   done = 1'b0;

  serial_twos_comp_array #(.WIDTH(W), .CHANNELS(CH)) dut (
    .t_clk(t_clk), .r_n(r_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_bit(in_bit), .mode(mode), .out_valid(out_valid), .out_sof(out_sof),
    .out_bit(out_bit), .ovf(ovf), .err_frame(err_frame)
  );

  always #5 t_clk = ~t_clk;
  always @(posedge t_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model(input logic [W-1:0] x, input logic [1:0] m,
                                output logic [W-1:0] r, output logic o);
    logic neg;
    neg = (m == 2'd1) || ((m == 2'd2) && x[W-1]);
    r   = (m == 2'd3) ? ~x : (neg ? (W'(0) - x) : x);
    o   = neg && (x == 8'h80);
  endfunction

  task automatic send_word(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [1:0] m, input bit gaps, input bit err_first);
    logic [W-1:0] r0, r1;
    logic         o0, o1;
    exp_t         e;
    model(w0, m, r0, o0);
    model(w1, m, r1, o1);
    for (int i = 0; i < W; i++) begin
      @(negedge t_clk);
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_bit   = {w1[i], w0[i]};
      mode     = (i == 0) ? m : ~m;
      if (i == 0 && err_first) err_cyc = cyc + 1;
      if (i == W - 1) begin
        for (int k = 0; k < W; k++) begin
          e.bits = {r1[k], r0[k]};
          e.sof  = (k == 0);
          e.ovf  = (k == W - 1) ? {o1, o0} : 2'b00;
          e.cyc  = cyc + 1 + k;
          q.push_back(e);
        end
      end else if (gaps) begin
        @(negedge t_clk);
        in_valid = 1'b0;
        in_sof   = 1'b1;
        in_bit   = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge t_clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_bit   = 2'($urandom_range(0, 3));
    end
  endtask

  // Output monitor: samples after the active edge settles.
  always begin
    @(posedge t_clk);
    #2;
    if (!done && r_n) begin
      chk("err_frame", {31'd0, err_frame}, {31'd0, cyc == err_cyc});
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("out_bit", {30'd0, out_bit}, {30'd0, e.bits});
          chk("out_sof", {31'd0, out_sof}, {31'd0, e.sof});
          chk("ovf", {30'd0, ovf}, {30'd0, e.ovf});
          chk("out_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_sof", {31'd0, out_sof}, 32'd0);
        if (q.size() > 0 && !q[0].sof) chk("out_gap", {31'd0, out_valid}, 32'd1);
        if (q.size() > 0 && cyc > q[0].cyc) chk("out_timeout", cyc, q[0].cyc);
      end
    end
  end

  initial begin
    r_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_bit = '0; mode = 2'd0;
    #23;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sof", {31'd0, out_sof}, 32'd0);
    chk("rst_bit", {30'd0, out_bit}, 32'd0);
    chk("rst_ovf", {30'd0, ovf}, 32'd0);
    chk("rst_err", {31'd0, err_frame}, 32'd0);
    @(negedge t_clk); r_n = 1'b1;
    idle(2);

    // stray non-sof beat at word boundary is dropped with an error
    @(negedge t_clk);
    in_valid = 1'b1; in_sof = 1'b0; in_bit = 2'b11; err_cyc = cyc + 1;
    idle(3);

    // NEG, then ABS and ONES back-to-back
    send_word(8'h05, 8'h01, 2'd1, 1'b0, 1'b0);
    send_word(8'hFB, 8'h05, 2'd2, 1'b0, 1'b0);
    send_word(8'h0F, 8'h0F, 2'd3, 1'b0, 1'b0);
    send_word(8'h3C, 8'hC3, 2'd0, 1'b0, 1'b0);
    idle(12);

    // most-negative overflow and zero
    send_word(8'h80, 8'h00, 2'd1, 1'b0, 1'b0);
    send_word(8'h80, 8'h7F, 2'd2, 1'b0, 1'b0);
    idle(12);

    // gapped input
    send_word(8'h05, 8'h01, 2'd1, 1'b1, 1'b0);
    idle(12);

    // restart in the middle of a word
    for (int i = 0; i < 3; i++) begin
      @(negedge t_clk);
      in_valid = 1'b1; in_sof = (i == 0); in_bit = 2'b01; mode = 2'd3;
    end
    send_word(8'h03, 8'h03, 2'd1, 1'b0, 1'b1);
    idle(12);

    // asynchronous reset mid-output
    send_word(8'h05, 8'h05, 2'd1, 1'b0, 1'b0);
    idle(1);
    @(posedge t_clk); @(posedge t_clk);
    #3;
    r_n = 1'b0;
    q.delete();
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_bit", {30'd0, out_bit}, 32'd0);
    chk("arst_sof", {31'd0, out_sof}, 32'd0);
    @(negedge t_clk); r_n = 1'b1;
    idle(12);
    send_word(8'h02, 8'h02, 2'd1, 1'b0, 1'b0);
    idle(14);

    chk("drained", q.size(), 32'd0);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
